// File: rtl/riscv_pkg.sv
// Shared RISC-V instruction constants used by the fetch front end and MainControl.
package riscv_pkg;

  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_supported_opcode(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/ifu_fifo2.sv
// Two-entry synchronous FIFO with flush; the head is read straight from storage.
module ifu_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_reg [2];
  logic         rd_ptr_reg;
  logic         wr_ptr_reg;
  logic [1:0]   count_reg;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && (count_reg != 2'd2);
  assign pop_ok  = pop && (count_reg != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      // Stored words are left in place; the empty count hides them.
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop_ok) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RISC-V fetch front end: PC, imem request issue, 2-deep instruction queue, redirect flush.
// Optional head-opcode legality flag is built only when IFU_OPCODE_CHECK_EN is defined.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_illegal
);

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] req_pc_reg;
  logic            inflight_reg;
  logic            drop_reg;
  logic [1:0]      count;
  logic            pop;
  logic            push;
  logic [2:0]      pending;
  logic [XLEN+INSTR_W-1:0] head;
  logic [1:0]      unused_low_bits;

  assign unused_low_bits = redirect_pc[1:0];

  assign pop     = if_valid && if_ready;
  // Entries already queued plus the one in flight, net of this cycle's pop.
  assign pending = {1'b0, count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign imem_req  = rst_n && !redirect && (pending < 3'd2);
  assign imem_addr = fetch_pc_reg;
  assign push      = inflight_reg && !drop_reg && !redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      inflight_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      inflight_reg <= imem_req;
      drop_reg     <= redirect && inflight_reg;
      if (redirect) fetch_pc_reg <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (imem_req) fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
      if (imem_req) req_pc_reg <= fetch_pc_reg;
    end
  end

  ifu_fifo2 #(.W(XLEN + INSTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({req_pc_reg, imem_rdata}),
    .dout  (head),
    .count (count)
  );

  assign if_valid = (count != 2'd0);
  assign if_pc    = head[XLEN+INSTR_W-1:INSTR_W];
  assign if_instr = head[INSTR_W-1:0];

`ifdef IFU_OPCODE_CHECK_EN
  assign if_illegal = if_valid && !is_supported_opcode(if_instr[6:0]);
`else
  assign if_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: sequential-stream reference model with redirects.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_illegal;

  logic        w_req, w_valid, w_illegal;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [31:0] w_rdata = 32'h0;

`ifdef IFU_OPCODE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_illegal(if_illegal)
  );

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .if_valid(w_valid), .if_ready(1'b1),
    .if_instr(w_instr), .if_pc(w_pc), .redirect(1'b0),
    .redirect_pc(32'h0), .if_illegal(w_illegal)
  );

  logic [31:0] poison_addr = 32'h1;
  logic [31:0] legal_addr  = 32'h1;

  // Memory content is a function of the address so any word can be predicted.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == poison_addr) return 32'hFFFF_FFFF;
    if (a == legal_addr) return 32'h0000_0033;
    return ~a;
  endfunction

  function automatic logic exp_ill(input logic v, input logic [31:0] ins);
    logic [6:0] op;
    logic ok;
    op = ins[6:0];
    ok = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
         (op == 7'b0100011) || (op == 7'b1100011);
    return CHK && v && !ok;
  endfunction

  always @(posedge clk) begin
    imem_rdata <= imem_req ? word(imem_addr) : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? word(w_addr) : 32'hDEAD_BEEF;
  end

  int errors = 0;
  int checks = 0;

  logic        x_valid, x_req, x_ill;
  logic [31:0] x_addr, x_pc, x_instr;
  logic [31:0] m_pc, m_fetch;
  int          m_out;

  task automatic sample();
    @(negedge clk);
    x_valid = if_valid; x_req = imem_req; x_ill = if_illegal;
    x_addr = imem_addr; x_pc = if_pc; x_instr = if_instr;
  endtask

  // Reference model: decode sees consecutive words from the last target; a redirect restarts it.
  task automatic advance();
    if (x_valid && if_ready) begin
      $display("xfer pc=%h instr=%h", x_pc, x_instr);
      m_pc = m_pc + 32'd4;
      m_out--;
    end
    if (x_req) begin
      m_fetch = m_fetch + 32'd4;
      m_out++;
    end
    if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_fetch = m_pc;
      m_out = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = 32'h0; m_fetch = 32'h0; m_out = 0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) begin sample(); advance(); end
    rst_n = 1'b0;
    @(posedge clk);
    sample();
    checks++;
    if (x_req !== 1'b0 || x_addr !== 32'h0 || x_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: req=%b addr=%h valid=%b, expected 0/00000000/0", x_req, x_addr, x_valid);
    end
    checks++;
    if (x_instr !== 32'h0 || x_pc !== 32'h0 || x_ill !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: instr=%h pc=%h ill=%b, expected 0/0/0", x_instr, x_pc, x_ill);
    end
  endtask

  task automatic test_stream();
    do_reset();
    if_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      sample();
      if (c == 0) begin
        checks++;
        if (x_req !== 1'b1 || x_addr !== 32'h0) begin
          errors++;
          $display("FAIL stream_first_req: req=%b addr=%h, expected 1/00000000", x_req, x_addr);
        end
      end
      checks++;
      if (x_valid !== (c >= 2)) begin
        errors++;
        $display("FAIL stream_valid c=%0d: valid=%b, expected %b", c, x_valid, c >= 2);
      end
      if (x_req) begin
        checks++;
        if (x_addr !== m_fetch) begin
          errors++;
          $display("FAIL stream_addr: addr=%h, expected %h", x_addr, m_fetch);
        end
      end
      if (x_valid) begin
        checks++;
        if (x_pc !== m_pc || x_instr !== word(m_pc)) begin
          errors++;
          $display("FAIL stream_order: pc=%h instr=%h, expected %h/%h", x_pc, x_instr, m_pc, word(m_pc));
        end
      end
      checks++;
      if (x_ill !== exp_ill(x_valid, x_instr)) begin
        errors++;
        $display("FAIL stream_illegal: ill=%b, expected %b", x_ill, exp_ill(x_valid, x_instr));
      end
      advance();
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if_ready = !(c >= 2 && c < 7);
      sample();
      if (c >= 2 && c < 7) begin
        checks++;
        if (x_valid !== 1'b1 || x_pc !== 32'h0 || x_instr !== word(32'h0)) begin
          errors++;
          $display("FAIL stall_hold c=%0d: valid=%b pc=%h instr=%h, expected 1/0/%h", c, x_valid, x_pc, x_instr, word(32'h0));
        end
      end
      if (c == 7) begin
        checks++;
        if (x_pc !== 32'h0) begin
          errors++;
          $display("FAIL stall_resume: pc=%h, expected 00000000", x_pc);
        end
      end
      if (x_req) begin
        checks++;
        if (x_addr !== m_fetch) begin
          errors++;
          $display("FAIL stall_addr: addr=%h, expected %h", x_addr, m_fetch);
        end
      end
      if (x_valid && if_ready) begin
        checks++;
        if (x_pc !== m_pc || x_instr !== word(m_pc)) begin
          errors++;
          $display("FAIL stall_order: pc=%h instr=%h, expected %h/%h", x_pc, x_instr, m_pc, word(m_pc));
        end
      end
      advance();
      checks++;
      if (m_out > 2) begin
        errors++;
        $display("FAIL stall_occupancy: outstanding=%0d, expected <=2", m_out);
      end
    end
  endtask

  task automatic test_redirect();
    int r;
    do_reset();
    if_ready = 1'b1;
    r = $urandom_range(4, 9);
    for (int c = 0; c < r + 9; c++) begin
      redirect = (c == r);
      redirect_pc = 32'h0000_0103;
      sample();
      if (c == r) begin
        checks++;
        if (x_req !== 1'b0) begin
          errors++;
          $display("FAIL redir_req_block: req=%b, expected 0", x_req);
        end
      end
      if (c == r + 1) begin
        checks++;
        if (x_req !== 1'b1 || x_addr !== 32'h100) begin
          errors++;
          $display("FAIL redir_target_req: req=%b addr=%h, expected 1/00000100", x_req, x_addr);
        end
      end
      if (c == r + 1 || c == r + 2) begin
        checks++;
        if (x_valid !== 1'b0) begin
          errors++;
          $display("FAIL redir_bubble c=%0d: valid=%b, expected 0", c, x_valid);
        end
      end
      if (c == r + 3) begin
        checks++;
        if (x_valid !== 1'b1 || x_pc !== 32'h100 || x_instr !== word(32'h100)) begin
          errors++;
          $display("FAIL redir_target: valid=%b pc=%h instr=%h, expected 1/00000100/%h", x_valid, x_pc, x_instr, word(32'h100));
        end
      end
      if (x_valid) begin
        checks++;
        if (x_pc !== m_pc || x_instr !== word(m_pc)) begin
          errors++;
          $display("FAIL redir_order: pc=%h instr=%h, expected %h/%h", x_pc, x_instr, m_pc, word(m_pc));
        end
      end
      advance();
    end
    redirect = 1'b0;
  endtask

  task automatic test_back_to_back();
    int r;
    do_reset();
    if_ready = 1'b1;
    r = $urandom_range(4, 8);
    for (int c = 0; c < r + 10; c++) begin
      redirect = (c == r) || (c == r + 1);
      redirect_pc = (c == r) ? 32'h200 : 32'h300;
      sample();
      if (c == r + 1) begin
        checks++;
        if (x_req !== 1'b0) begin
          errors++;
          $display("FAIL b2b_req_block: req=%b, expected 0", x_req);
        end
      end
      if (c == r + 2) begin
        checks++;
        if (x_req !== 1'b1 || x_addr !== 32'h300) begin
          errors++;
          $display("FAIL b2b_target_req: req=%b addr=%h, expected 1/00000300", x_req, x_addr);
        end
      end
      if (c == r + 4) begin
        checks++;
        if (x_valid !== 1'b1 || x_pc !== 32'h300) begin
          errors++;
          $display("FAIL b2b_target: valid=%b pc=%h, expected 1/00000300", x_valid, x_pc);
        end
      end
      checks++;
      if ((x_req && x_addr[31:8] == 24'h2) || (x_valid && x_pc[31:8] == 24'h2)) begin
        errors++;
        $display("FAIL b2b_stale: req=%b addr=%h valid=%b pc=%h, expected nothing from 0x2xx", x_req, x_addr, x_valid, x_pc);
      end
      if (x_valid) begin
        checks++;
        if (x_pc !== m_pc || x_instr !== word(m_pc)) begin
          errors++;
          $display("FAIL b2b_order: pc=%h instr=%h, expected %h/%h", x_pc, x_instr, m_pc, word(m_pc));
        end
      end
      advance();
    end
    redirect = 1'b0;
  endtask

  task automatic test_random();
    logic        prev_stall;
    logic [31:0] prev_pc, prev_instr;
    do_reset();
    prev_stall = 1'b0; prev_pc = 32'h0; prev_instr = 32'h0;
    for (int c = 0; c < 300; c++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      sample();
      if (prev_stall) begin
        checks++;
        if (x_valid !== 1'b1 || x_pc !== prev_pc || x_instr !== prev_instr) begin
          errors++;
          $display("FAIL rand_stable: valid=%b pc=%h instr=%h, expected 1/%h/%h", x_valid, x_pc, x_instr, prev_pc, prev_instr);
        end
      end
      if (x_req) begin
        checks++;
        if (x_addr !== m_fetch || x_addr[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL rand_addr: addr=%h, expected %h", x_addr, m_fetch);
        end
      end
      if (x_valid) begin
        checks++;
        if (x_pc !== m_pc || x_instr !== word(m_pc)) begin
          errors++;
          $display("FAIL rand_order: pc=%h instr=%h, expected %h/%h", x_pc, x_instr, m_pc, word(m_pc));
        end
      end
      checks++;
      if (x_ill !== exp_ill(x_valid, x_instr)) begin
        errors++;
        $display("FAIL rand_illegal: ill=%b, expected %b", x_ill, exp_ill(x_valid, x_instr));
      end
      prev_stall = x_valid && !if_ready && !redirect;
      prev_pc = x_pc; prev_instr = x_instr;
      advance();
      checks++;
      if (m_out > 2) begin
        errors++;
        $display("FAIL rand_occupancy: outstanding=%0d, expected <=2", m_out);
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] wf, wp;
    do_reset();
    wf = 32'hFFFF_FFF8; wp = 32'hFFFF_FFF8;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (w_req !== 1'b1 || w_addr !== wf) begin
        errors++;
        $display("FAIL wrap_addr c=%0d: req=%b addr=%h, expected 1/%h", c, w_req, w_addr, wf);
      end
      wf = wf + 32'd4;
      if (c >= 2) begin
        checks++;
        if (w_valid !== 1'b1 || w_pc !== wp || w_instr !== word(wp)) begin
          errors++;
          $display("FAIL wrap_out c=%0d: valid=%b pc=%h instr=%h, expected 1/%h/%h", c, w_valid, w_pc, w_instr, wp, word(wp));
        end
        wp = wp + 32'd4;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
    poison_addr = 32'h8;
    legal_addr  = 32'hC;
    do_reset();
    if_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (x_valid && x_pc == 32'h8) begin
        checks++;
        if (x_instr !== 32'hFFFF_FFFF || x_ill !== CHK) begin
          errors++;
          $display("FAIL illegal_ffff: instr=%h ill=%b, expected ffffffff/%b", x_instr, x_ill, CHK);
        end
      end
      if (x_valid && x_pc == 32'hC) begin
        checks++;
        if (x_instr !== 32'h33 || x_ill !== 1'b0) begin
          errors++;
          $display("FAIL illegal_rtype: instr=%h ill=%b, expected 00000033/0", x_instr, x_ill);
        end
      end
      advance();
    end
    poison_addr = 32'h1;
    legal_addr  = 32'h1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_random();
    test_wrap();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
